// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution block:
//   - conditional-branch funct3 encodings
//   - bit positions of the ALU compare flags {V,C,N,Z} (flags of A - B)
//   - resolution FSM state type
// -----------------------------------------------------------------------------
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Purely combinational branch condition evaluation.
// Ports:
//   funct3  in  [2:0]  branch funct3
//   flags   in  [3:0]  compare flags {V,C,N,Z} of A - B
//   taken   out        condition holds (always 0 for an illegal encoding)
//   illegal out        funct3 is not a conditional-branch encoding (010/011)
// C is the "no borrow" carry, so unsigned A < B is ~C.
// -----------------------------------------------------------------------------
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = flags[FLAG_Z];
      F3_BNE:  taken = ~flags[FLAG_Z];
      F3_BLT:  taken = flags[FLAG_N] ^ flags[FLAG_V];
      F3_BGE:  taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      F3_BLTU: taken = ~flags[FLAG_C];
      F3_BGEU: taken = flags[FLAG_C];
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Resolves a conditional branch, reports the result one cycle after
// acceptance and, on a mispredict, flushes and redirects fetch.
//
// Build option: define BRANCH_STATS_EN to add the stat_branches and
// stat_mispredicts counters (ports and logic absent otherwise).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        branch input handshake
//   in_funct3, in_flags        branch type and compare flags {V,C,N,Z}
//   in_pc, in_imm              branch PC and sign-extended B-immediate
//   in_pred_taken              fetch-stage prediction
//   res_valid/taken/mispredict one-cycle resolution result at T+1
//   redir_valid/ready, redir_pc redirect handshake towards fetch
//   flush                      one-cycle pulse killing younger instructions
//   illegal_br, misalign       one-cycle exception pulses
//   stat_branches, stat_mispredicts  (BRANCH_STATS_EN only)
//   dbg_state                  current FSM state
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. in_ready is high exactly when the FSM is IDLE. Once
// redir_valid is raised, redir_valid and redir_pc stay stable until a
// rising edge samples redir_ready high; only reset withdraws them early.
// -----------------------------------------------------------------------------
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [3:0]      in_flags,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush,
  output logic            illegal_br,
  output logic            misalign,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output br_state_e       dbg_state
);

  br_state_e       state;
  br_state_e       state_next;
  logic            accept;
  logic            cond_taken;
  logic            cond_illegal;
  logic            target_misalign;
  logic            mispredict;
  logic            redirect_issue;
  logic [XLEN-1:0] target;

  branch_cond u_cond (
    .funct3  (in_funct3),
    .flags   (in_flags),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Carry out of the add is dropped: targets wrap modulo 2^XLEN.
  assign target          = cond_taken ? (in_pc + in_imm) : (in_pc + XLEN'(4));
  assign target_misalign = cond_taken && (target[1:0] != 2'b00);

  // Illegal and misaligned branches raise their own exception instead of
  // redirecting, so they never count as a mispredict.
  assign mispredict     = (cond_taken ^ in_pred_taken) && !cond_illegal && !target_misalign;
  assign redirect_issue = accept && mispredict;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (redirect_issue) state_next = REDIRECT;
      REDIRECT: if (redir_ready)    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign dbg_state   = state;
  // redir_valid is a decode of the state register, so it rises at T+1 and
  // falls on the edge after redir_ready is sampled (or on reset).
  assign redir_valid = (state == REDIRECT);

  // ---------------------------------------------------------------------------
  // Registered result and pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
      flush          <= 1'b0;
      illegal_br     <= 1'b0;
      misalign       <= 1'b0;
      redir_pc       <= '0;
    end else begin
      res_valid      <= accept;
      res_taken      <= accept && cond_taken;
      res_mispredict <= redirect_issue;
      flush          <= redirect_issue;
      illegal_br     <= accept && cond_illegal;
      misalign       <= accept && target_misalign;
      // Only loaded when a redirect is issued, so it holds in REDIRECT.
      if (redirect_issue) begin
        redir_pc <= target;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (accept && !cond_illegal) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (redirect_issue) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule
